// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-access stage.
// Insn-type codes, funct3 access codes and the MEM/WB bundle.
package mem_stage_pkg;

  localparam logic [3:0] NO_TYPE = 4'h0;
  localparam logic [3:0] R_TYPE  = 4'h1;
  localparam logic [3:0] I_TYPE  = 4'h2;
  localparam logic [3:0] L_TYPE  = 4'h3;
  localparam logic [3:0] S_TYPE  = 4'h4;
  localparam logic [3:0] B_TYPE  = 4'h5;
  localparam logic [3:0] J_TYPE  = 4'h6;
  localparam logic [3:0] U_TYPE  = 4'h7;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  typedef struct packed {
    logic [3:0]  insn_type;
    logic [4:0]  rd;
    logic [31:0] ex_val;
    logic [31:0] mem_r_data;
  } mem_wb_t;

  // Unsigned byte/half codes only exist for loads;
  // anything unrecognised is a full-word access.
  function automatic size_e acc_size(
    input logic [2:0] f3,
    input logic       st
  );
    size_e sz;
    sz = SZ_W;
    unique case (1'b1)
      (f3 == F3_B):             sz = SZ_B;
      (f3 == F3_H):             sz = SZ_H;
      (!st && f3 == F3_BU):     sz = SZ_B;
      (!st && f3 == F3_HU):     sz = SZ_H;
      default:                  sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and extraction for loads.
// Purely combinational; also flags misaligned accesses.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        store_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_val_o,
  output logic        misalign_o
);

  size_e       sz;
  logic        uns;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign sz     = acc_size(funct3_i, store_i);
  assign uns    = funct3_i[2];
  assign byte_v = rdata_i[{off_i, 3'b000} +: 8];
  assign half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Size-dependent lane enables, data replication and extension.
  always_comb begin
    wstrb_o    = 4'b1111;
    wdata_o    = st_data_i;
    ld_val_o   = rdata_i;
    misalign_o = 1'b0;
    unique case (sz)
      SZ_B: begin
        wstrb_o    = 4'b0001 << off_i;
        wdata_o    = {4{st_data_i[7:0]}};
        ld_val_o   = uns ? {24'd0, byte_v}
                         : {{24{byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        wstrb_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{st_data_i[15:0]}};
        ld_val_o   = uns ? {16'd0, half_v}
                         : {{16{half_v[15]}}, half_v};
        misalign_o = off_i[0];
      end
      default: begin
        misalign_o = |off_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data port, MEM/WB register,
// upstream stall while waiting, watchdog abort on no ack.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  insn_type,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] ex_val,
  input  logic [31:0] st_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [3:0]  wb_insn_type,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_ex_val,
  output logic [31:0] wb_mem_r_data,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wbv_q, wbv_d;
  mem_wb_t           wb_q, wb_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;
  logic [3:0]        ty_q, ty_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       ev_q, ev_d;

  logic              idle, is_ld, is_st;
  logic [2:0]        al_f3;
  logic              al_st;
  logic [1:0]        al_off;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_wdata, al_ld;
  logic              al_mis;

  assign idle   = (state_q == S_IDLE);
  assign is_ld  = (insn_type == L_TYPE);
  assign is_st  = (insn_type == S_TYPE);
  assign al_f3  = idle ? funct3 : f3_q;
  assign al_st  = idle ? is_st : we_q;
  assign al_off = idle ? ex_val[1:0] : ev_q[1:0];

  mem_lane_align u_align (
    .funct3_i   (al_f3),
    .store_i    (al_st),
    .off_i      (al_off),
    .st_data_i  (st_data),
    .rdata_i    (dmem_rdata),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .ld_val_o   (al_ld),
    .misalign_o (al_mis)
  );

  // Next state: accept, wait for ack, or abort on timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    ty_d    = ty_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    ev_d    = ev_q;
    wbv_d   = 1'b0;
    wb_d    = '0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && (is_ld || is_st)) begin
          if (al_mis) begin
            mis_d = 1'b1;
          end else begin
            req_d   = 1'b1;
            we_d    = is_st;
            addr_d  = {ex_val[31:2], 2'b00};
            wstrb_d = is_st ? al_wstrb : 4'd0;
            wdata_d = is_st ? al_wdata : 32'd0;
            ty_d    = insn_type;
            rd_d    = rd;
            f3_d    = funct3;
            ev_d    = ex_val;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end else if (in_valid) begin
          wbv_d           = 1'b1;
          wb_d.insn_type  = insn_type;
          wb_d.rd         = rd;
          wb_d.ex_val     = ex_val;
        end
      end
      S_WAIT: begin
        if (dmem_ack || cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wstrb_d = '0;
          wdata_d = '0;
          state_d = S_IDLE;
        end
        if (dmem_ack) begin
          wbv_d           = 1'b1;
          wb_d.insn_type  = ty_q;
          wb_d.rd         = we_q ? 5'd0 : rd_q;
          wb_d.ex_val     = ev_q;
          wb_d.mem_r_data = we_q ? 32'd0 : al_ld;
        end else if (cnt_q == CNT_LAST) begin
          berr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State, port and MEM/WB registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      wbv_q   <= 1'b0;
      wb_q    <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      ty_q    <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      wbv_q   <= wbv_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      ty_q    <= ty_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      ev_q    <= ev_d;
    end
  end

  assign in_ready      = idle;
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wstrb    = wstrb_q;
  assign dmem_wdata    = wdata_q;
  assign wb_valid      = wbv_q;
  assign wb_insn_type  = wb_q.insn_type;
  assign wb_rd         = wb_q.rd;
  assign wb_ex_val     = wb_q.ex_val;
  assign wb_mem_r_data = wb_q.mem_r_data;
  assign misalign      = mis_q;
  assign bus_err       = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table plus
// hand sequences for stalls, timeout and async reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  insn_type;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] ex_val;
  logic [31:0] st_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [3:0]  wb_insn_type;
  logic [4:0]  wb_rd;
  logic [31:0] wb_ex_val;
  logic [31:0] wb_mem_r_data;
  logic        misalign;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  mem_stage #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .insn_type     (insn_type),
    .funct3        (funct3),
    .rd            (rd),
    .ex_val        (ex_val),
    .st_data       (st_data),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_insn_type  (wb_insn_type),
    .wb_rd         (wb_rd),
    .wb_ex_val     (wb_ex_val),
    .wb_mem_r_data (wb_mem_r_data),
    .misalign      (misalign),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  ty;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] ev;
    logic [31:0] sd;
    logic [31:0] rdat;
    logic        x_req;
    logic [3:0]  x_strb;
    logic [31:0] x_wdata;
    logic        x_mis;
    logic        x_wbv;
    logic [4:0]  x_rd;
    logic [31:0] x_mrd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic v, logic [3:0] ty, logic [2:0] f3,
    logic [4:0] r, logic [31:0] ev, logic [31:0] sd,
    logic [31:0] rdat, logic xq, logic [3:0] xs,
    logic [31:0] xw, logic xm, logic xv,
    logic [4:0] xr, logic [31:0] xd
  );
    vec_t t;
    t.v = v; t.ty = ty; t.f3 = f3; t.rd = r;
    t.ev = ev; t.sd = sd; t.rdat = rdat;
    t.x_req = xq; t.x_strb = xs; t.x_wdata = xw;
    t.x_mis = xm; t.x_wbv = xv; t.x_rd = xr;
    t.x_mrd = xd;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [3:0] ty, logic [2:0] f3,
                       logic [4:0] r, logic [31:0] ev,
                       logic [31:0] sd);
    in_valid  = v;
    insn_type = ty;
    funct3    = f3;
    rd        = r;
    ex_val    = ev;
    st_data   = sd;
  endtask

  task automatic idle_in();
    drive(1'b0, 4'h0, 3'd0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic chk_quiet(string nm);
    chk({nm, ".req"}, 32'(dmem_req), 32'd0);
    chk({nm, ".wbv"}, 32'(wb_valid), 32'd0);
    chk({nm, ".rd"}, 32'(wb_rd), 32'd0);
    chk({nm, ".ty"}, 32'(wb_insn_type), 32'd0);
    chk({nm, ".ev"}, wb_ex_val, 32'd0);
    chk({nm, ".mrd"}, wb_mem_r_data, 32'd0);
  endtask

  initial begin
    int n;
    string nm;
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    idle_in();

    vecs.push_back(mk(1, R_TYPE, 3'd0, 5'd5, 32'h1234, 0, 0,
                      0, 0, 0, 0, 1, 5'd5, 0));
    vecs.push_back(mk(1, L_TYPE, F3_B, 5'd6, 32'h103, 0,
                      32'h80FF_0000, 1, 0, 0, 0, 1, 5'd6,
                      32'hFFFF_FF80));
    vecs.push_back(mk(1, L_TYPE, F3_BU, 5'd7, 32'h101, 0,
                      32'h1234_8A56, 1, 0, 0, 0, 1, 5'd7,
                      32'h0000_008A));
    vecs.push_back(mk(1, L_TYPE, F3_H, 5'd8, 32'h102, 0,
                      32'h9ABC_0011, 1, 0, 0, 0, 1, 5'd8,
                      32'hFFFF_9ABC));
    vecs.push_back(mk(1, L_TYPE, F3_HU, 5'd9, 32'h100, 0,
                      32'h1111_F00D, 1, 0, 0, 0, 1, 5'd9,
                      32'h0000_F00D));
    vecs.push_back(mk(1, L_TYPE, F3_W, 5'd10, 32'h200, 0,
                      32'hDEAD_BEEF, 1, 0, 0, 0, 1, 5'd10,
                      32'hDEAD_BEEF));
    vecs.push_back(mk(1, S_TYPE, F3_B, 5'd11, 32'h301,
                      32'h1122_3344, 0, 1, 4'b0010,
                      32'h4444_4444, 0, 1, 5'd0, 0));
    vecs.push_back(mk(1, S_TYPE, F3_W, 5'd12, 32'h400,
                      32'hCAFE_F00D, 0, 1, 4'b1111,
                      32'hCAFE_F00D, 0, 1, 5'd0, 0));
    vecs.push_back(mk(1, S_TYPE, F3_H, 5'd13, 32'h500,
                      32'h0000_5678, 0, 1, 4'b0011,
                      32'h5678_5678, 0, 1, 5'd0, 0));
    vecs.push_back(mk(1, L_TYPE, F3_W, 5'd14, 32'h102, 0, 0,
                      0, 0, 0, 1, 0, 5'd0, 0));
    vecs.push_back(mk(1, L_TYPE, F3_H, 5'd15, 32'h101, 0, 0,
                      0, 0, 0, 1, 0, 5'd0, 0));
    vecs.push_back(mk(1, S_TYPE, F3_W, 5'd16, 32'h403, 1, 0,
                      0, 0, 0, 1, 0, 5'd0, 0));
    vecs.push_back(mk(0, R_TYPE, 3'd0, 5'd7, 32'h5555, 0, 0,
                      0, 0, 0, 0, 0, 5'd0, 0));
    vecs.push_back(mk(1, L_TYPE, 3'b111, 5'd17, 32'h104, 0,
                      32'h0102_0304, 1, 0, 0, 0, 1, 5'd17,
                      32'h0102_0304));
    vecs.push_back(mk(1, L_TYPE, F3_B, 5'd18, 32'h100, 0,
                      32'h0000_007F, 1, 0, 0, 0, 1, 5'd18,
                      32'h0000_007F));
    vecs.push_back(mk(1, I_TYPE, 3'd0, 5'd19, 32'h7777, 0, 0,
                      0, 0, 0, 0, 1, 5'd19, 0));

    #12;
    chk_quiet("rst");
    chk("rst.rdy", 32'(in_ready), 32'd1);
    chk("rst.berr", 32'(bus_err), 32'd0);
    tick();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      nm = $sformatf("v%0d", i);
      drive(vecs[i].v, vecs[i].ty, vecs[i].f3, vecs[i].rd,
            vecs[i].ev, vecs[i].sd);
      tick();
      idle_in();
      chk({nm, ".req"}, 32'(dmem_req), 32'(vecs[i].x_req));
      if (vecs[i].x_req) begin
        chk({nm, ".addr"}, dmem_addr, {vecs[i].ev[31:2], 2'b00});
        chk({nm, ".we"}, 32'(dmem_we), 32'(vecs[i].ty == S_TYPE));
        chk({nm, ".strb"}, 32'(dmem_wstrb), 32'(vecs[i].x_strb));
        chk({nm, ".wdat"}, dmem_wdata, vecs[i].x_wdata);
        chk({nm, ".rdy"}, 32'(in_ready), 32'd0);
        chk({nm, ".wbv0"}, 32'(wb_valid), 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = vecs[i].rdat;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        chk({nm, ".req1"}, 32'(dmem_req), 32'd0);
        chk({nm, ".ev"}, wb_ex_val, vecs[i].ev);
        chk({nm, ".ty"}, 32'(wb_insn_type), 32'(vecs[i].ty));
      end else begin
        chk({nm, ".mis"}, 32'(misalign), 32'(vecs[i].x_mis));
        chk({nm, ".ev"}, wb_ex_val,
            vecs[i].x_wbv ? vecs[i].ev : 32'd0);
        chk({nm, ".ty"}, 32'(wb_insn_type),
            vecs[i].x_wbv ? 32'(vecs[i].ty) : 32'd0);
      end
      chk({nm, ".wbv"}, 32'(wb_valid), 32'(vecs[i].x_wbv));
      chk({nm, ".rd"}, 32'(wb_rd), 32'(vecs[i].x_rd));
      chk({nm, ".mrd"}, wb_mem_r_data, vecs[i].x_mrd);
      chk({nm, ".berr"}, 32'(bus_err), 32'd0);
    end

    // SH with delayed ack: port held stable, stage stalled.
    drive(1, S_TYPE, F3_H, 5'd3, 32'h202, 32'h0000_ABCD);
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      chk("sh.req", 32'(dmem_req), 32'd1);
      chk("sh.addr", dmem_addr, 32'h200);
      chk("sh.strb", 32'(dmem_wstrb), 32'hC);
      chk("sh.wdat", dmem_wdata, 32'hABCD_ABCD);
      chk("sh.rdy", 32'(in_ready), 32'd0);
      chk("sh.wbv0", 32'(wb_valid), 32'd0);
      tick();
    end
    chk("sh.wdat3", dmem_wdata, 32'hABCD_ABCD);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sh.wbv", 32'(wb_valid), 32'd1);
    chk("sh.rd", 32'(wb_rd), 32'd0);
    chk("sh.berr", 32'(bus_err), 32'd0);
    tick();
    chk("sh.bub", 32'(wb_valid), 32'd0);

    // Never acked: request high exactly TIMEOUT cycles.
    drive(1, L_TYPE, F3_W, 5'd4, 32'h600, 32'd0);
    tick();
    idle_in();
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      tick();
    end
    chk("to.cycles", 32'(n), 32'd4);
    chk("to.berr", 32'(bus_err), 32'd1);
    chk("to.rdy", 32'(in_ready), 32'd1);
    chk_quiet("to");
    tick();
    chk("to.berr1", 32'(bus_err), 32'd0);

    // Ack on the last cycle before timeout wins.
    drive(1, L_TYPE, F3_W, 5'd21, 32'h604, 32'd0);
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) tick();
    chk("ta.req", 32'(dmem_req), 32'd1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_CAFE;
    tick();
    dmem_ack   = 1'b0;
    chk("ta.wbv", 32'(wb_valid), 32'd1);
    chk("ta.berr", 32'(bus_err), 32'd0);
    chk("ta.rd", 32'(wb_rd), 32'd21);
    chk("ta.mrd", wb_mem_r_data, 32'h0BAD_CAFE);

    // Asynchronous reset in the middle of an access.
    drive(1, S_TYPE, F3_W, 5'd1, 32'h700, 32'h1);
    tick();
    idle_in();
    chk("ar.req0", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.req", 32'(dmem_req), 32'd0);
    chk("ar.we", 32'(dmem_we), 32'd0);
    chk("ar.addr", dmem_addr, 32'd0);
    chk("ar.strb", 32'(dmem_wstrb), 32'd0);
    chk("ar.wdat", dmem_wdata, 32'd0);
    chk("ar.rdy", 32'(in_ready), 32'd1);
    chk_quiet("ar");
    tick();
    rst_n = 1'b1;
    drive(1, R_TYPE, 3'd0, 5'd9, 32'h9999, 32'd0);
    tick();
    chk("pr.wbv", 32'(wb_valid), 32'd1);
    chk("pr.rd", 32'(wb_rd), 32'd9);
    drive(1, L_TYPE, F3_HU, 5'd2, 32'h802, 32'd0);
    tick();
    idle_in();
    chk("pr.req", 32'(dmem_req), 32'd1);
    chk("pr.addr", dmem_addr, 32'h800);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBEEF_0001;
    tick();
    dmem_ack   = 1'b0;
    chk("pr.mrd", wb_mem_r_data, 32'h0000_BEEF);
    chk("pr.rd2", 32'(wb_rd), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
